fk_pll_seq: RTL and testbench

FK_PLL_SEQ -- requirements
Module: fk_pll_seq

---
 rtl/fk_pll_pkg.sv | 29 ++
 rtl/fk_spi_shifter.sv | 45 ++++
 rtl/fk_pll_seq.sv | 180 ++++++++++++++++++
 tb/tb_fk_pll_seq.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fk_pll_pkg.sv
// Shared state encoding, radio word layout and limits for the channel-hop PLL sequencer.
package fk_pll_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        CAL    = 3'd2,
        SHIFT  = 3'd3,
        SETTLE = 3'd4,
        DONE   = 3'd5
    } pll_state_t;

    localparam int          WORD_W      = 16;
    localparam logic [3:0]  ADDR_CH     = 4'h3;
    localparam logic [3:0]  ADDR_CAL    = 4'h5;
    localparam logic [11:0] CAL_PAYLOAD = 12'h001;
    localparam logic [6:0]  FK_MAX      = 7'd78;
    localparam logic [8:0]  SETTLE_DEF  = 9'd450;

    localparam logic [WORD_W-1:0] CAL_WORD = {ADDR_CAL, CAL_PAYLOAD};

    // Each serial bit spans two clocks, so a word occupies 2*WORD_W cycles.
    localparam logic [4:0] LAST_PHASE = 5'(2 * WORD_W - 1);

    function automatic logic [WORD_W-1:0] chan_word(input logic tx, input logic [6:0] ch);
        return {ADDR_CH, tx, 4'h0, ch};
    endfunction

endpackage

// File: rtl/fk_spi_shifter.sv
// MSB-first serial shifter to the radio: two clocks per bit, sclk high on the second.
module fk_spi_shifter
    import fk_pll_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [WORD_W-1:0] word,
    output logic              sclk,
    output logic              sdata,
    output logic              sen,
    output logic              done
);

    logic [WORD_W-1:0] sreg;
    logic [4:0]        phase;
    logic              active;

    always_ff @(posedge clk) begin
        if (rst) begin
            sreg   <= '0;
            phase  <= '0;
            active <= 1'b0;
        end else if (load) begin
            sreg   <= word;
            phase  <= '0;
            active <= 1'b1;
        end else if (active) begin
            phase <= phase + 5'd1;
            // Advance after the high half so new data appears while sclk is low.
            if (phase[0]) begin
                sreg <= {sreg[WORD_W-2:0], 1'b0};
            end
            if (phase == LAST_PHASE) begin
                active <= 1'b0;
            end
        end
    end

    assign sen   = active;
    assign sclk  = active & phase[0];
    assign sdata = active & sreg[WORD_W-1];
    assign done  = active && (phase == LAST_PHASE);

endmodule

// File: rtl/fk_pll_seq.sv
// Channel-hop PLL sequencer: writes the channel word to the radio, then times PLL settle.
// Build option FK_PLL_SEQ_CAL_EN sends a calibration word (plus 2-cycle gap) before each channel word.
module fk_pll_seq
    import fk_pll_pkg::*;
(
    input  logic       clk_6M,
    input  logic       rst,
    input  logic       p_033us,
    input  logic       fk_chg_p,
    input  logic [6:0] fk,
    input  logic       txbit_period,
    input  logic [8:0] regi_pll_settle,
    output logic       rf_sclk,
    output logic       rf_sdata,
    output logic       rf_sen,
    output logic       fkset_p,
    output logic       pll_busy,
    output logic [6:0] fk_cur,
    output logic       fk_err_p
);

    pll_state_t state;
    pll_state_t state_nx;

    logic [6:0]        cap_fk;
    logic              cap_tx;
    logic              pend_vld;
    logic [6:0]        pend_fk;
    logic              pend_tx;
    logic [8:0]        settle_cnt;
    logic [8:0]        settle_tgt;
    logic              sh_load;
    logic [WORD_W-1:0] sh_word;
    logic              sh_done;
    logic              req;
    logic [6:0]        req_fk;
    logic              req_tx;
    logic              settle_hit;

`ifdef FK_PLL_SEQ_CAL_EN
    logic [1:0]        gap_cnt;
`endif

    // fk_chg_p is a request with no back-pressure: taken straight into LOAD when the
    // sequencer can start a word, otherwise parked in a one-deep pending slot (newest wins).
    assign req    = fk_chg_p | pend_vld;
    assign req_fk = fk_chg_p ? fk : pend_fk;
    assign req_tx = fk_chg_p ? txbit_period : pend_tx;

    assign settle_hit = (settle_cnt == settle_tgt) ||
                        (p_033us && ((settle_cnt + 9'd1) == settle_tgt));

    always_ff @(posedge clk_6M) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        sh_load  = 1'b0;
        sh_word  = chan_word(cap_tx, cap_fk);
        fk_err_p = 1'b0;
        fkset_p  = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    state_nx = LOAD;
                end
            end
            LOAD: begin
                if (cap_fk > FK_MAX) begin
                    fk_err_p = 1'b1;
                    state_nx = IDLE;
                end else begin
                    sh_load = 1'b1;
`ifdef FK_PLL_SEQ_CAL_EN
                    sh_word  = CAL_WORD;
                    state_nx = CAL;
`else
                    state_nx = SHIFT;
`endif
                end
            end
            CAL: begin
`ifdef FK_PLL_SEQ_CAL_EN
                if (gap_cnt == 2'd1) begin
                    sh_load  = 1'b1;
                    state_nx = SHIFT;
                end
`else
                state_nx = IDLE;
`endif
            end
            SHIFT: begin
                if (sh_done) begin
                    state_nx = req ? LOAD : SETTLE;
                end
            end
            SETTLE: begin
                if (req) begin
                    state_nx = LOAD;
                end else if (settle_hit) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                fkset_p  = 1'b1;
                state_nx = req ? LOAD : IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_6M) begin
        if (rst) begin
            cap_fk     <= '0;
            cap_tx     <= 1'b0;
            pend_vld   <= 1'b0;
            pend_fk    <= '0;
            pend_tx    <= 1'b0;
            settle_cnt <= '0;
            settle_tgt <= '0;
            fk_cur     <= '0;
        end else begin
            if (state_nx == LOAD) begin
                cap_fk   <= req_fk;
                cap_tx   <= req_tx;
                pend_vld <= 1'b0;
            end else if (fk_chg_p) begin
                pend_vld <= 1'b1;
                pend_fk  <= fk;
                pend_tx  <= txbit_period;
            end

            if (state == SHIFT && sh_done) begin
                fk_cur     <= cap_fk;
                settle_cnt <= '0;
                settle_tgt <= regi_pll_settle;
            end else if (state == SETTLE && p_033us && settle_cnt != settle_tgt) begin
                settle_cnt <= settle_cnt + 9'd1;
            end
        end
    end

`ifdef FK_PLL_SEQ_CAL_EN
    // gap_cnt runs 2,1 across the two idle cycles between calibration and channel words.
    always_ff @(posedge clk_6M) begin
        if (rst) begin
            gap_cnt <= '0;
        end else if (state == CAL) begin
            if (sh_done) begin
                gap_cnt <= 2'd2;
            end else if (gap_cnt != 2'd0) begin
                gap_cnt <= gap_cnt - 2'd1;
            end
        end else begin
            gap_cnt <= '0;
        end
    end
`endif

    fk_spi_shifter u_shifter (
        .clk   (clk_6M),
        .rst   (rst),
        .load  (sh_load),
        .word  (sh_word),
        .sclk  (rf_sclk),
        .sdata (rf_sdata),
        .sen   (rf_sen),
        .done  (sh_done)
    );

    assign pll_busy = (state != IDLE);

endmodule

// File: tb/tb_fk_pll_seq.sv
// Self-checking bench for fk_pll_seq: scoreboard of expected radio words and settle events.
`timescale 1ns/1ps
module tb_fk_pll_seq;
    import fk_pll_pkg::*;

    logic       clk_6M = 1'b0;
    logic       rst;
    logic       p_033us;
    logic       fk_chg_p;
    logic [6:0] fk;
    logic       txbit_period;
    logic [8:0] regi_pll_settle;
    logic       rf_sclk;
    logic       rf_sdata;
    logic       rf_sen;
    logic       fkset_p;
    logic       pll_busy;
    logic [6:0] fk_cur;
    logic       fk_err_p;

    int n_chk = 0;
    int n_err = 0;

    logic [15:0] exp_q[$];
    logic [15:0] set_q[$];

    int          cyc = 0;
    int          rise_cnt = 0;
    int          err_cnt = 0;
    int          sen_len = 0;
    int          fall_cyc = 0;
    int          last_sen_cyc = 0;
    int          tick_cnt = 0;
    logic        prev_sen = 1'b0;
    logic        bad = 1'b0;
    logic        hold_d = 1'b0;
    logic [15:0] acc = '0;
    logic [15:0] last_word = '0;
    logic [15:0] e = '0;

    fk_pll_seq dut (
        .clk_6M          (clk_6M),
        .rst             (rst),
        .p_033us         (p_033us),
        .fk_chg_p        (fk_chg_p),
        .fk              (fk),
        .txbit_period    (txbit_period),
        .regi_pll_settle (regi_pll_settle),
        .rf_sclk         (rf_sclk),
        .rf_sdata        (rf_sdata),
        .rf_sen          (rf_sen),
        .fkset_p         (fkset_p),
        .pll_busy        (pll_busy),
        .fk_cur          (fk_cur),
        .fk_err_p        (fk_err_p)
    );

    // ---------------- clock / reset / tick ----------------
    always #83 clk_6M = ~clk_6M;

    initial begin
        p_033us = 1'b0;
        forever begin
            @(negedge clk_6M);
            p_033us = ~p_033us;
        end
    end

    initial begin
        #8000000;
        $display("FAIL watchdog: got no finish, want finish");
        $fatal(1);
    end

    // ---------------- check task ----------------
    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, act, exp);
        end
    endtask

    // ---------------- model helpers ----------------
    function automatic logic [15:0] chan(input logic [6:0] f, input logic t);
        return {4'h3, t, 4'h0, f};
    endfunction

    task automatic push_word(input logic [15:0] w);
`ifdef FK_PLL_SEQ_CAL_EN
        exp_q.push_back(16'h5001);
`endif
        exp_q.push_back(w);
    endtask

    task automatic push_set(input logic [8:0] s, input logic [6:0] f);
        set_q.push_back({s, f});
    endtask

    // ---------------- driver tasks ----------------
    task automatic pulse(input logic [6:0] f, input logic t);
        @(negedge clk_6M);
        fk = f;
        txbit_period = t;
        fk_chg_p = 1'b1;
        @(negedge clk_6M);
        fk_chg_p = 1'b0;
    endtask

    task automatic pulse_lat(input logic [6:0] f, input logic t, output int lat);
        lat = 0;
        @(negedge clk_6M);
        fk = f;
        txbit_period = t;
        fk_chg_p = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk_6M);
            if (i == 1) fk_chg_p = 1'b0;
            if (rf_sen) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk_6M);
            n++;
        end while (pll_busy && n < budget);
        check("idle_reached", 32'(pll_busy), 32'd0);
    endtask

    task automatic wait_sen(input logic lvl, input int budget);
        int n;
        n = 0;
        while (rf_sen !== lvl && n < budget) begin
            @(negedge clk_6M);
            n++;
        end
        check("sen_level", 32'(rf_sen), 32'(lvl));
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk_6M) begin
        #1;
        cyc++;
        if (fk_err_p) err_cnt++;
        if (rst) begin
            prev_sen  = 1'b0;
            sen_len   = 0;
            last_word = '0;
        end else begin
            if (rf_sen) begin
                if (!prev_sen) begin
                    rise_cnt++;
                    sen_len = 0;
                    acc = '0;
                    bad = 1'b0;
`ifdef FK_PLL_SEQ_CAL_EN
                    if (last_word == 16'h5001) check("cal_gap", cyc - fall_cyc, 32'd2);
`endif
                end
                sen_len++;
                if (sen_len % 2 == 1) begin
                    if (rf_sclk) bad = 1'b1;
                    hold_d = rf_sdata;
                end else begin
                    if (!rf_sclk || rf_sdata !== hold_d) bad = 1'b1;
                    acc = {acc[14:0], rf_sdata};
                end
            end else if (prev_sen) begin
                fall_cyc = cyc;
                last_sen_cyc = cyc - 1;
                tick_cnt = p_033us ? 1 : 0;
                check("sen_len", sen_len, 32'd32);
                check("sclk_shape", 32'(bad), 32'd0);
                check("word_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) check("rf_word", 32'(acc), 32'(exp_q.pop_front()));
                last_word = acc;
            end else if (fkset_p) begin
                check("fkset_expected", 32'(set_q.size() != 0), 32'd1);
                if (set_q.size() != 0) begin
                    e = set_q.pop_front();
                    if (e[15:7] == 9'd0) check("settle0_lat", cyc - last_sen_cyc, 32'd2);
                    else check("settle_ticks", tick_cnt, 32'(e[15:7]));
                    check("fk_cur_at_set", 32'(fk_cur), 32'(e[6:0]));
                end
            end else if (p_033us) begin
                tick_cnt++;
            end
            prev_sen = rf_sen;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int lat;
        int e0;
        int r0;
        logic [6:0] rf;
        logic       rt;
        logic [8:0] rs;

        rst = 1'b1;
        fk_chg_p = 1'b0;
        fk = '0;
        txbit_period = 1'b0;
        regi_pll_settle = 9'd450;

        // reset state, including a request that must be ignored under reset
        repeat (3) @(negedge clk_6M);
        fk = 7'd12;
        fk_chg_p = 1'b1;
        @(negedge clk_6M);
        fk_chg_p = 1'b0;
        check("rst_busy", 32'(pll_busy), 32'd0);
        check("rst_sen", 32'(rf_sen), 32'd0);
        check("rst_sclk", 32'(rf_sclk), 32'd0);
        check("rst_sdata", 32'(rf_sdata), 32'd0);
        check("rst_fkset", 32'(fkset_p), 32'd0);
        check("rst_err", 32'(fk_err_p), 32'd0);
        check("rst_fk_cur", 32'(fk_cur), 32'd0);
        rst = 1'b0;
        @(negedge clk_6M);
        check("busy_after_rst", 32'(pll_busy), 32'd0);

        // fk=37 TX, default settle
        push_word(16'h3825);
        push_set(9'd450, 7'd37);
        pulse_lat(7'd37, 1'b1, lat);
        check("lat_from_idle", lat, 32'd2);
        wait_idle(4000);
        check("fk_cur_37", 32'(fk_cur), 32'd37);

        // illegal channel
        e0 = err_cnt;
        r0 = rise_cnt;
        pulse(7'd79, 1'b0);
        wait_idle(50);
        repeat (3) @(negedge clk_6M);
        check("err_pulse_len", err_cnt - e0, 32'd1);
        check("no_sen_on_err", rise_cnt - r0, 32'd0);
        check("fk_cur_kept", 32'(fk_cur), 32'd37);

        // two requests during SHIFT: newest wins, first settle abandoned
        regi_pll_settle = 9'd20;
        push_word(chan(7'd10, 1'b0));
        push_word(chan(7'd30, 1'b1));
        push_set(9'd20, 7'd30);
        pulse(7'd10, 1'b0);
        wait_sen(1'b1, 20);
        repeat (4) @(negedge clk_6M);
        pulse(7'd20, 1'b1);
        pulse(7'd30, 1'b1);
        wait_idle(4000);
        check("fk_cur_30", 32'(fk_cur), 32'd30);

        // request during SETTLE aborts it immediately
        regi_pll_settle = 9'd40;
        push_word(chan(7'd4, 1'b0));
        push_word(chan(7'd5, 1'b0));
        push_set(9'd40, 7'd5);
        pulse(7'd4, 1'b0);
        wait_sen(1'b1, 20);
        wait_sen(1'b0, 80);
`ifdef FK_PLL_SEQ_CAL_EN
        wait_sen(1'b1, 20);
        wait_sen(1'b0, 80);
`endif
        repeat (10) @(negedge clk_6M);
        pulse_lat(7'd5, 1'b0, lat);
        check("lat_from_settle", lat, 32'd2);
        wait_idle(4000);
        check("fk_cur_5", 32'(fk_cur), 32'd5);

        // zero settle
        regi_pll_settle = 9'd0;
        push_word(chan(7'd50, 1'b1));
        push_set(9'd0, 7'd50);
        pulse(7'd50, 1'b1);
        wait_idle(400);
        check("fk_cur_50", 32'(fk_cur), 32'd50);

        // random legal channels
        for (int i = 0; i < 4; i++) begin
            rf = 7'($urandom_range(0, 78));
            rt = 1'($urandom_range(0, 1));
            rs = 9'($urandom_range(0, 12));
            regi_pll_settle = rs;
            push_word(chan(rf, rt));
            push_set(rs, rf);
            pulse(rf, rt);
            wait_idle(1000);
            check("fk_cur_rand", 32'(fk_cur), 32'(rf));
        end

        // reset at bit 7 of the first word on the wire
        regi_pll_settle = 9'd450;
        r0 = rise_cnt;
        pulse(7'd60, 1'b1);
        wait_sen(1'b1, 20);
        repeat (14) @(negedge clk_6M);
        rst = 1'b1;
        @(negedge clk_6M);
        check("midrst_sen", 32'(rf_sen), 32'd0);
        check("midrst_sclk", 32'(rf_sclk), 32'd0);
        check("midrst_sdata", 32'(rf_sdata), 32'd0);
        check("midrst_busy", 32'(pll_busy), 32'd0);
        check("midrst_fk_cur", 32'(fk_cur), 32'd0);
        check("midrst_fkset", 32'(fkset_p), 32'd0);
        rst = 1'b0;
        repeat (40) @(negedge clk_6M);
        check("no_word_after_rst", rise_cnt - r0, 32'd1);

        // highest legal channel after recovery
        regi_pll_settle = 9'd3;
        push_word(chan(7'd78, 1'b0));
        push_set(9'd3, 7'd78);
        pulse(7'd78, 1'b0);
        wait_idle(400);
        check("fk_cur_78", 32'(fk_cur), 32'd78);

        repeat (5) @(negedge clk_6M);
        check("words_left", exp_q.size(), 32'd0);
        check("sets_left", set_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
